// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-subset CPU: fetch/decode/execute/memory/write-back sequencing.
// Define MULTICYCLE_CTRL_OVF_EXC_EN to turn ALU signed overflow on add/sub/addi into an exception.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_w,
    output logic       mem_w,
    output logic       ir_w,
    output logic       regwrite,
    output logic       iord,
    output logic [1:0] reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       epc_w,
    output logic [1:0] cause,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_FETCH_W  = 4'd2,
        S_DECODE   = 4'd3,
        S_EXEC_R   = 4'd4,
        S_WB_R     = 4'd5,
        S_EXEC_I   = 4'd6,
        S_WB_I     = 4'd7,
        S_ADDR     = 4'd8,
        S_MEM_RD   = 4'd9,
        S_MEM_RD_W = 4'd10,
        S_MEM_WB   = 4'd11,
        S_MEM_WR   = 4'd12,
        S_BRANCH   = 4'd13,
        S_JUMP     = 4'd14,
        S_EXC      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] CAUSE_UNDEF = 2'd0;
    localparam logic [1:0] CAUSE_OVF   = 2'd1;

    state_t     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic [2:0] r_alu_op_q;
    logic       is_sw_q, is_bne_q, is_jal_q;
    logic       r_funct_ok;
    logic [2:0] r_alu_op;
    logic       ovf_exc;

    always_comb begin
        r_funct_ok = 1'b1;
        r_alu_op   = ALU_ADD;
        case (funct)
            6'h20:   r_alu_op = ALU_ADD;
            6'h22:   r_alu_op = ALU_SUB;
            6'h24:   r_alu_op = ALU_AND;
            6'h25:   r_alu_op = ALU_OR;
            6'h2A:   r_alu_op = ALU_SLT;
            default: r_funct_ok = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_CTRL_OVF_EXC_EN
    // Only add, sub and addi trap; the flag is captured in DECODE so EXEC knows.
    logic ovf_chk_q;
    assign ovf_exc = ovf_chk_q & overflow;
`else
    logic overflow_unused;
    assign overflow_unused = overflow;
    assign ovf_exc         = 1'b0;
`endif

    always_comb begin
        state_d = S_FETCH;
        cause_d = cause_q;
        case (state_q)
            S_FETCH:    state_d = S_FETCH_W;
            S_FETCH_W:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = r_funct_ok ? S_EXEC_R : S_EXC;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J, OP_JAL:  state_d = S_JUMP;
                    default:       state_d = S_EXC;
                endcase
                if (state_d == S_EXC) cause_d = CAUSE_UNDEF;
            end
            S_EXEC_R: begin
                state_d = ovf_exc ? S_EXC : S_WB_R;
                if (ovf_exc) cause_d = CAUSE_OVF;
            end
            S_EXEC_I: begin
                state_d = ovf_exc ? S_EXC : S_WB_I;
                if (ovf_exc) cause_d = CAUSE_OVF;
            end
            S_ADDR:     state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = S_MEM_RD_W;
            S_MEM_RD_W: state_d = S_MEM_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RST;
            cause_q    <= CAUSE_UNDEF;
            r_alu_op_q <= ALU_ADD;
            is_sw_q    <= 1'b0;
            is_bne_q   <= 1'b0;
            is_jal_q   <= 1'b0;
`ifdef MULTICYCLE_CTRL_OVF_EXC_EN
            ovf_chk_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == S_DECODE) begin
                r_alu_op_q <= r_alu_op;
                is_sw_q    <= (opcode == OP_SW);
                is_bne_q   <= (opcode == OP_BNE);
                is_jal_q   <= (opcode == OP_JAL);
`ifdef MULTICYCLE_CTRL_OVF_EXC_EN
                ovf_chk_q  <= (opcode == OP_ADDI) ||
                              ((opcode == OP_RTYPE) && ((funct == 6'h20) || (funct == 6'h22)));
`endif
            end
        end
    end

    // Moore decode from the registered state, so reset clears every output at once.
    always_comb begin
        pc_w       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        pc_source  = 2'd0;
        epc_w      = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'd1;
                pc_w      = 1'b1;
            end
            S_FETCH_W:  ir_w = 1'b1;
            S_DECODE:   alu_src_b = 2'd3;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu_op_q;
            end
            S_WB_R: begin
                reg_dst  = 2'd1;
                regwrite = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_WB_I:     regwrite = 1'b1;
            S_MEM_RD, S_MEM_RD_W: iord = 1'b1;
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                regwrite   = 1'b1;
            end
            S_MEM_WR: begin
                iord  = 1'b1;
                mem_w = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'd1;
                pc_w      = is_bne_q ? ~zero : zero;
            end
            S_JUMP: begin
                pc_source = 2'd2;
                pc_w      = 1'b1;
                if (is_jal_q) begin
                    reg_dst  = 2'd2;
                    regwrite = 1'b1;
                end
            end
            S_EXC: begin
                epc_w     = 1'b1;
                pc_source = 2'd3;
                pc_w      = 1'b1;
            end
            default: ;
        endcase
    end

    assign cause = cause_q;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction model queues the expected cycle-by-cycle control word.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, overflow;
    logic       pc_w, mem_w, ir_w, regwrite, iord, mem_to_reg, alu_src_a, epc_w;
    logic [1:0] reg_dst, alu_src_b, pc_source, cause;
    logic [2:0] alu_op;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
        .pc_w(pc_w), .mem_w(mem_w), .ir_w(ir_w), .regwrite(regwrite), .iord(iord), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .epc_w(epc_w), .cause(cause), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_w, mem_w, ir_w, regwrite, iord;
        logic [1:0] reg_dst;
        logic       mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       epc_w;
        logic [1:0] cause;
    } rec_t;

`ifdef MULTICYCLE_CTRL_OVF_EXC_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    rec_t       act;
    rec_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [1:0] exp_cause = 2'd0;

    assign act = {state, pc_w, mem_w, ir_w, regwrite, iord, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, alu_op, pc_source, epc_w, cause};

    function automatic rec_t step(input logic [3:0] st);
        rec_t r = '0;
        r.st    = st;
        r.cause = exp_cause;
        return r;
    endfunction

    function automatic logic [2:0] r_op(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b001;
            6'h24:   return 3'b010;
            6'h25:   return 3'b011;
            6'h2A:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control words for one instruction, FETCH through its last step.
    function automatic int model(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
        rec_t r;
        int   n = 0;
        bit   is_r  = (op == 6'h00) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
        bit   arith = (op == 6'h08) || (is_r && (fn inside {6'h20, 6'h22}));
        r = step(4'd1); r.pc_w = 1; r.alu_src_b = 2'd1; sb.push_back(r); n++;
        r = step(4'd2); r.ir_w = 1; sb.push_back(r); n++;
        r = step(4'd3); r.alu_src_b = 2'd3; sb.push_back(r); n++;
        if (is_r || op == 6'h08) begin
            r = step(is_r ? 4'd4 : 4'd6); r.alu_src_a = 1;
            r.alu_src_b = is_r ? 2'd0 : 2'd2; r.alu_op = is_r ? r_op(fn) : 3'd0;
            sb.push_back(r); n++;
            if (OVF_EN && arith && ov) begin
                exp_cause = 2'd1;
                r = step(4'd15); r.epc_w = 1; r.pc_source = 2'd3; r.pc_w = 1; sb.push_back(r); n++;
            end else begin
                r = step(is_r ? 4'd5 : 4'd7); r.regwrite = 1; r.reg_dst = is_r ? 2'd1 : 2'd0;
                sb.push_back(r); n++;
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            r = step(4'd8); r.alu_src_a = 1; r.alu_src_b = 2'd2; sb.push_back(r); n++;
            if (op == 6'h23) begin
                r = step(4'd9);  r.iord = 1; sb.push_back(r); n++;
                r = step(4'd10); r.iord = 1; sb.push_back(r); n++;
                r = step(4'd11); r.mem_to_reg = 1; r.regwrite = 1; sb.push_back(r); n++;
            end else begin
                r = step(4'd12); r.iord = 1; r.mem_w = 1; sb.push_back(r); n++;
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            r = step(4'd13); r.alu_src_a = 1; r.alu_op = 3'b001; r.pc_source = 2'd1;
            r.pc_w = (op == 6'h05) ? !z : z; sb.push_back(r); n++;
        end else if (op == 6'h02 || op == 6'h03) begin
            r = step(4'd14); r.pc_source = 2'd2; r.pc_w = 1;
            if (op == 6'h03) begin r.reg_dst = 2'd2; r.regwrite = 1; end
            sb.push_back(r); n++;
        end else begin
            exp_cause = 2'd0;
            r = step(4'd15); r.epc_w = 1; r.pc_source = 2'd3; r.pc_w = 1; sb.push_back(r); n++;
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && sb.size() > 0) begin
            rec_t e;
            e = sb.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL step st=%0d/%0d got=%h want=%h", state, e.st, act, e);
            end
        end
    end

    // Called just after a negedge with the DUT in its last step (or RST); returns likewise.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
        int n;
        opcode = op; funct = fn; zero = z; overflow = ov;
        n = model(op, fn, z, ov);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        total++;
        if (act !== '0) begin
            bad++;
            $display("FAIL %s got=%h want=0", name, act);
        end
    endtask

    initial begin
        int n;
        logic [5:0] op, fn;
        reset = 1'b0; opcode = 6'h23; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
        #1 check_zero("reset_async");
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        #1 reset = 1'b1;

        run_instr(6'h23, 6'h00, 0, 0);
        run_instr(6'h00, 6'h20, 0, 0);
        run_instr(6'h00, 6'h20, 0, 1);
        run_instr(6'h00, 6'h22, 1, 1);
        run_instr(6'h00, 6'h24, 0, 1);
        run_instr(6'h00, 6'h25, 0, 0);
        run_instr(6'h00, 6'h2A, 1, 1);
        run_instr(6'h08, 6'h00, 0, 1);
        run_instr(6'h08, 6'h11, 0, 0);
        run_instr(6'h2B, 6'h00, 0, 0);
        run_instr(6'h04, 6'h00, 1, 0);
        run_instr(6'h04, 6'h00, 0, 0);
        run_instr(6'h05, 6'h00, 1, 0);
        run_instr(6'h05, 6'h00, 0, 0);
        run_instr(6'h02, 6'h00, 0, 0);
        run_instr(6'h03, 6'h00, 0, 0);
        run_instr(6'h3F, 6'h00, 0, 0);
        run_instr(6'h00, 6'h21, 0, 1);

        // Reset pulse while in MEM_WR of a store.
        opcode = 6'h2B; funct = 6'h00; zero = 0; overflow = 0;
        n = model(6'h2B, 6'h00, 0, 0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        sb.delete();
        exp_cause = 2'd0;
        #1 check_zero("reset_mid_memwr");
        @(negedge clk);
        #1 reset = 1'b1;
        run_instr(6'h08, 6'h00, 0, 0);

        for (int i = 0; i < 150; i++) begin
            fn = 6'h20;
            case ($urandom_range(0, 10))
                0, 1: begin
                    op = 6'h00;
                    case ($urandom_range(0, 5))
                        0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                        3: fn = 6'h25; 4: fn = 6'h2A; default: fn = 6'($urandom_range(0, 63));
                    endcase
                end
                2: op = 6'h08;
                3: op = 6'h23;
                4: op = 6'h2B;
                5: op = 6'h04;
                6: op = 6'h05;
                7: op = 6'h02;
                8: op = 6'h03;
                default: op = 6'($urandom_range(0, 63));
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
